// File: rtl/demux_1_5_hs.sv
// demux_1_5_hs: registered 1-to-5 valid/ready demultiplexer with per-channel one-entry holding registers.
// Latency: 1 cycle from input acceptance to out_valid/out_data of the selected channel.
// Backpressure: in_ready drops only when the selected channel is full and its consumer is not draining.
// Optional build macro DEMUX_AUTOSCAN_EN: select comes from an internal 0..4 scan counter (port scan_idx),
// in_sel is ignored, and err_sel/drop_cnt are tied to 0.
module demux_1_5_hs #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready,
  output logic [5*WIDTH-1:0] out_data,
  output logic               err_sel,
  output logic [CNT_W-1:0]   drop_cnt
`ifdef DEMUX_AUTOSCAN_EN
  ,
  output logic [2:0]         scan_idx
`endif
);

  localparam logic [2:0] LAST_CH = 3'd4;

  // Per-channel holding registers: full bit plus data word.
  logic [4:0]            valid_q, valid_d;
  logic [4:0][WIDTH-1:0] data_q,  data_d;

  // Effective select, legality and handshake terms.
  logic [2:0] sel_w;
  logic       sel_ok;
  logic [4:0] sel_oh;
  logic [4:0] drain;
  logic [4:0] fill;
  logic       accept;

`ifdef DEMUX_AUTOSCAN_EN
  // Scan counter replaces the external select; in_sel is intentionally left unused.
  logic [2:0] scan_q, scan_d;
  logic       unused_in_sel;

  assign unused_in_sel = ^in_sel;
  assign sel_w         = scan_q;
`else
  assign sel_w         = in_sel;
`endif

  // A select above the last channel is never steered anywhere.
  assign sel_ok = (sel_w <= LAST_CH);

  // One-hot decode of the select; all zeros for an illegal select.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < 5; k++) begin
      sel_oh[k] = (sel_w == 3'(k));
    end
  end

  // A channel drains whenever its register is full and its consumer takes it.
  assign drain = valid_q & out_ready;

  // Ready depends only on the selected channel state, never on in_valid.
  // An illegal select is always accepted so the stream cannot lock up on it.
  assign in_ready = sel_ok ? ((sel_oh & (~valid_q | out_ready)) != 5'b0) : 1'b1;

  assign accept = in_valid && in_ready;
  assign fill   = accept ? sel_oh : 5'b0;

  // Next-state of each holding register: refill wins over drain on the same edge.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < 5; k++) begin
      if (fill[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end else if (drain[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  // Holding registers; reset discards any stored or in-flight word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef DEMUX_AUTOSCAN_EN
  // Scan counter advances once per accepted word, wrapping after the last channel.
  always_comb begin
    scan_d = scan_q;
    if (accept) begin
      scan_d = (scan_q == LAST_CH) ? 3'd0 : scan_q + 3'd1;
    end
  end

  // Scan counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= 3'd0;
    end else begin
      scan_q <= scan_d;
    end
  end

  assign scan_idx = scan_q;
  assign err_sel  = 1'b0;
  assign drop_cnt = '0;
`else
  // Drop bookkeeping for words carrying an illegal select.
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop;

  assign drop = accept && !sel_ok;

  // Error pulse mirrors each dropped word; counter saturates instead of wrapping.
  always_comb begin
    err_d = drop;
    cnt_d = cnt_q;
    if (drop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Error pulse and drop counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_sel  = err_q;
  assign drop_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_1_5_hs.sv
// tb_demux_1_5_hs: self-checking bench for demux_1_5_hs (default build, WIDTH=8, CNT_W=2).
// Per-channel scoreboard queues are filled at acceptance and compared on each drain.
// Directed phases cover reset, steering, backpressure, throughput, drops, saturation and mid-run reset.
module tb_demux_1_5_hs;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_sel;
  logic [4:0]       out_valid;
  logic [4:0]       out_ready;
  logic [5*WIDTH-1:0] out_data;
  logic             err_sel;
  logic [CNT_W-1:0] drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [WIDTH-1:0] sb [5][$];

  demux_1_5_hs #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err_sel  (err_sel),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] ch_data(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable around the negative edge, so this sees what the next posedge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) sb[k].delete();
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          chk($sformatf("sb_occ%0d", k), 32'(sb[k].size() > 0), 32'd1);
          if (sb[k].size() > 0) chk($sformatf("sb_data%0d", k), 32'(ch_data(k)), 32'(sb[k].pop_front()));
        end
      end
      if (in_valid && in_ready && in_sel < 3'd5) sb[in_sel].push_back(in_data);
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 3'd0; in_data = 8'h55; out_ready = 5'b0;
    #1;

    // Reset held with a word offered.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_cnt",   32'(drop_cnt),  32'd0);
      chk("rst_err",   32'(err_sel),   32'd0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_cnt",   32'(drop_cnt),  32'd0);
    chk("post_rst_err",   32'(err_sel),   32'd0);

    // Steering into every channel with no consumer ready.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_sel = 3'(k); in_data = 8'hA0 + 8'(k);
      #1 chk("steer_rdy", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("steer_valid", 32'(out_valid), 32'h1f);
    for (int k = 0; k < 5; k++) chk($sformatf("steer_data%0d", k), 32'(ch_data(k)), 32'hA0 + 32'(k));

    // Full channel with stalled consumer backpressures.
    in_valid = 1'b1; in_sel = 3'd2; in_data = 8'hFF;
    #1 chk("bp_rdy", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_hold", 32'(ch_data(2)), 32'hA2);
    chk("bp_valid", 32'(out_valid), 32'h1f);

    // Full throughput on channel 3 with simultaneous drain and refill.
    out_ready = 5'b01000;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h10 + 8'(i);
      #1 chk("tp_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("tp_valid3", 32'(out_valid[3]), 32'd1);
      chk("tp_data3",  32'(ch_data(3)), 32'h10 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'b10111);
    chk("drain_hold3", 32'(ch_data(3)), 32'h12);
    out_ready = 5'b0;

    // Back-to-back illegal selects.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hE0 + 8'(i);
      in_sel = (i == 0) ? 3'd5 : (i == 1) ? 3'd7 : 3'd6;
      #1 chk("inv_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("inv_err",   32'(err_sel),   32'd1);
      chk("inv_cnt",   32'(drop_cnt),  32'(i + 1));
      chk("inv_valid", 32'(out_valid), 32'b10111);
    end
    in_valid = 1'b0;
    tick();
    chk("inv_err_end", 32'(err_sel),  32'd0);
    chk("inv_cnt_end", 32'(drop_cnt), 32'd3);

    // Reset with channels 1 and 4 full and a transfer to channel 3 in progress.
    in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h77; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data_lo", out_data[31:0], 32'd0);
    chk("mrst_data_hi", 32'(out_data[39:32]), 32'd0);
    chk("mrst_cnt", 32'(drop_cnt), 32'd0);

    // Saturating drop counter (2 bits).
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sel = 3'd5; in_data = 8'(i);
      tick();
      chk("sat_cnt", 32'(drop_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      chk("sat_err", 32'(err_sel), 32'd1);
    end
    in_valid = 1'b0;

    // Refill of one channel concurrent with drains of two others.
    for (int k = 1; k < 3; k++) begin
      in_valid = 1'b1; in_sel = 3'(k); in_data = 8'hC0 + 8'(k);
      tick();
    end
    out_ready = 5'b00110; in_sel = 3'd0; in_data = 8'h3C;
    tick();
    in_valid = 1'b0; out_ready = 5'b0;
    chk("mix_valid", 32'(out_valid), 32'b00001);
    chk("mix_data0", 32'(ch_data(0)), 32'h3C);

    // Random traffic; the scoreboard compares every drained word.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = 8'($urandom);
      out_ready = 5'($urandom);
      tick();
    end

    // Drain everything and confirm nothing was lost or duplicated.
    in_valid = 1'b0; out_ready = 5'h1f;
    tick(); tick();
    chk("final_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 5; k++) chk($sformatf("final_sb%0d", k), 32'(sb[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_1_5_hs.md
Name: demux_1_5_hs

Overview:
- Registered 1-to-5 demultiplexer with valid/ready handshaking. It is the distribution-side counterpart of the 5:1 selector in the mux library.
- Accepts one word per transfer on a single input stream and steers it to one of five output channels chosen by a 3-bit select.
- Each output channel has a one-entry holding register, so each downstream consumer can stall independently.
- Out-of-range selects (5..7) are consumed, dropped and counted.

Parameters:
- WIDTH, 8, data word width of the input and of each output channel
- CNT_W, 8, width of the saturating drop counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low; one clock only, sampled on the rising edge of clk
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the input word this cycle
- in_data  input  WIDTH  input word
- in_sel  input  3  destination channel, 0..4 valid, 5..7 invalid
- out_valid  output  5  per-channel holding register full
- out_ready  input  5  per-channel consumer accepts
- out_data  output  5*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- err_sel  output  1  one-cycle pulse: an invalid-select word was dropped
- drop_cnt  output  CNT_W  saturating count of dropped words

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_data=0, err_sel=0, drop_cnt=0.
  - Any in-flight word is discarded.
  - in_ready is still evaluated combinationally during reset, but no state updates.
- in_ready is combinational:
  - in_sel>4 -> 1.
  - Otherwise -> !out_valid[in_sel] || out_ready[in_sel].
  - in_ready must not depend on in_valid.
- Transfer occurs when in_valid && in_ready at a clk edge.
- Accepted word with valid in_sel=k:
  - Next cycle, out_valid[k]=1 and out_data[k]=in_data.
  - Latency is exactly 1 cycle.
  - No other channel's register changes.
- Drain: out_valid[k] && out_ready[k] at an edge clears out_valid[k], unless channel k is refilled on the same edge.
  - Simultaneous drain and refill of the same channel: out_valid[k] stays 1 and out_data[k] takes the new word.
  - This allows full throughput of 1 word/cycle per channel.
- Drains on different channels, and a refill of one channel concurrent with drains of others, are independent and all take effect on the same edge.
- out_data[k] holds its value while out_valid[k]=0. It is don't-care to consumers but must not change except on refill or reset.
- Accepted word with in_sel in 5..7:
  - No channel is written.
  - err_sel=1 for exactly the next cycle.
  - drop_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
- Back-to-back invalid words keep err_sel high on consecutive cycles, one increment per word.
- in_valid=0: no state change other than drains.
- No internal FSM beyond the per-channel full/empty bit (EMPTY -> FULL on fill; FULL -> EMPTY on drain without refill).

Optional Feature:
- Macro: DEMUX_AUTOSCAN_EN.
- Defined (scan mode):
  - in_sel is ignored and need not be driven.
  - An internal 3-bit scan counter selects the channel and is exposed on an extra output port scan_idx [2:0].
  - The counter resets to 0 and advances by 1 per accepted transfer, wrapping 4 -> 0.
  - in_ready = !out_valid[scan_idx] || out_ready[scan_idx].
  - err_sel is tied 0 and drop_cnt is tied 0.
  - Use case: de-interleaving a 5-slot TDM stream.
- Undefined: select comes from in_sel exactly as described above; port scan_idx does not exist.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=5'b00000, drop_cnt=0, err_sel=0 throughout and one cycle after release.
- Steering: send 0xA0..0xA4 with in_sel=0..4, all out_ready=0 -> after 5 cycles out_valid=5'b11111 and out_data[k]=0xA0+k.
- Then in_sel=2 with data 0xFF -> in_ready=0, and data is held.
- Backpressure and throughput: channel 3 full, out_ready[3]=1, in_valid=1 with in_sel=3 on consecutive cycles with data 0x10,0x11,0x12 -> in_ready stays 1, out_valid[3] stays 1, and out_data[3] sequences 0x10,0x11,0x12 one cycle after each acceptance.
- Invalid select: send in_sel=5,7,6 back-to-back -> err_sel high for 3 consecutive cycles, drop_cnt=3, out_valid unchanged.
- Saturation: with CNT_W=2, send 5 invalid words -> drop_cnt reads 1,2,3,3,3.
- Reset mid-operation: channels 1 and 4 full and a transfer in progress; assert rst_n=0 for one edge -> all out_valid=0 and out_data=0 next cycle. In DEMUX_AUTOSCAN_EN builds also check: scan_idx returns to 0 after reset, and 7 accepted words leave scan_idx=2.
